// File: rtl/uart_rx_core_if.sv
// uart_rx_core_if: serial line, frame config and received-byte pulses of the UART receiver
interface uart_rx_core_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
);
    logic                  RX_IN;
    logic [PRESC_W-1:0]    Prescale;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;
    modport master (
        output RX_IN, Prescale, PAR_EN, PAR_TYP,
        input  P_DATA, data_valid, par_err, stp_err
    );
    modport slave (
        input  RX_IN, Prescale, PAR_EN, PAR_TYP,
        output P_DATA, data_valid, par_err, stp_err
    );
endinterface

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver with parity/stop checking; define UART_RX_MAJORITY_EN for 2-of-3 bit voting
module uart_rx_core #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input logic           CLK,
    input logic           RST,
    uart_rx_core_if.slave bus
);
    localparam int BW = $clog2(DATA_WIDTH);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
    state_t                state_q, state_d;
    logic [PRESC_W-1:0]    edge_q, edge_d, presc_q, presc_d, half, last, presc_in;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d, p_data_q, p_data_d;
    logic                  par_en_q, par_en_d, par_typ_q, par_typ_d;
    logic                  par_flag_q, par_flag_d, stp_flag_q, stp_flag_d;
    logic                  dv_q, dv_d, pe_q, pe_d, se_q, se_d;
    logic                  wrap, arm, samp_en, samp_val;
    assign half     = presc_q >> 1;
    assign last     = presc_q - PRESC_W'(1);
    assign wrap     = edge_q == last;
    assign presc_in = (bus.Prescale < PRESC_W'(4)) ? PRESC_W'(4) : bus.Prescale;
`ifdef UART_RX_MAJORITY_EN
    logic [1:0] maj_q, maj_d;
    assign samp_en  = edge_q == half + PRESC_W'(1);
    assign samp_val = (maj_q[0] & maj_q[1]) | (maj_q[0] & bus.RX_IN) | (maj_q[1] & bus.RX_IN);
    // hold the two early votes until the deciding third sample arrives
    always_comb begin
        maj_d[0] = (edge_q == half - PRESC_W'(1)) ? bus.RX_IN : maj_q[0];
        maj_d[1] = (edge_q == half) ? bus.RX_IN : maj_q[1];
    end
    // vote registers
    always_ff @(posedge CLK) maj_q <= RST ? 2'b00 : maj_d;
`else
    assign samp_en  = edge_q == half;
    assign samp_val = bus.RX_IN;
`endif
    // frame sequencing; a good stop bit re-arms start detection in its last cycle so back-to-back frames keep their pitch
    always_comb begin
        state_d    = state_q;
        edge_d     = wrap ? '0 : edge_q + PRESC_W'(1);
        bit_d      = bit_q;
        shift_d    = shift_q;
        presc_d    = presc_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        par_flag_d = par_flag_q;
        stp_flag_d = stp_flag_q;
        p_data_d   = p_data_q;
        dv_d       = 1'b0;
        pe_d       = 1'b0;
        se_d       = 1'b0;
        arm        = 1'b0;
        case (state_q)
            IDLE: arm = 1'b1;
            START: begin
                if (samp_en && samp_val) state_d = IDLE;
                else if (wrap) state_d = DATA;
            end
            DATA: begin
                if (samp_en) shift_d[bit_q] = samp_val;
                if (wrap) begin
                    bit_d = bit_q + BW'(1);
                    if (bit_q == BW'(DATA_WIDTH - 1)) state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (samp_en && (samp_val != (^shift_q ^ par_typ_q))) par_flag_d = 1'b1;
                if (wrap) state_d = STOP;
            end
            STOP: begin
                if (samp_en && !samp_val) stp_flag_d = 1'b1;
                if (wrap) begin
                    dv_d     = !par_flag_q && !stp_flag_d;
                    pe_d     = par_flag_q;
                    se_d     = stp_flag_d;
                    p_data_d = dv_d ? shift_q : p_data_q;
                    state_d  = stp_flag_d ? BREAK : IDLE;
                    arm      = !stp_flag_d;
                end
            end
            default: if (bus.RX_IN) state_d = IDLE;
        endcase
        if (arm) begin
            edge_d     = '0;
            bit_d      = '0;
            par_flag_d = 1'b0;
            stp_flag_d = 1'b0;
        end
        if (arm && !bus.RX_IN) begin
            state_d   = START;
            presc_d   = presc_in;
            par_en_d  = bus.PAR_EN;
            par_typ_d = bus.PAR_TYP;
        end
    end
    // state, datapath and registered output pulses
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            edge_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            presc_q    <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_flag_q <= 1'b0;
            stp_flag_q <= 1'b0;
            p_data_q   <= '0;
            dv_q       <= 1'b0;
            pe_q       <= 1'b0;
            se_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_q     <= edge_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            presc_q    <= presc_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            par_flag_q <= par_flag_d;
            stp_flag_q <= stp_flag_d;
            p_data_q   <= p_data_d;
            dv_q       <= dv_d;
            pe_q       <= pe_d;
            se_q       <= se_d;
        end
    end
    assign bus.P_DATA     = p_data_q;
    assign bus.data_valid = dv_q;
    assign bus.par_err    = pe_q;
    assign bus.stp_err    = se_q;
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed frames with hand-computed pulse cycles and bytes
module tb_uart_rx_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   dv_n, pe_n, se_n, dv_cyc, dv_cyc_prev, pe_cyc, se_cyc;
    logic [7:0] dv_data, dv_data_prev;
    uart_rx_core_if bus ();
    uart_rx_core dut (.CLK(clk), .RST(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // pulse monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.data_valid === 1'b1) begin
            dv_n++;
            dv_cyc_prev = dv_cyc;
            dv_data_prev = dv_data;
            dv_cyc = cyc;
            dv_data = bus.P_DATA;
        end
        if (bus.par_err === 1'b1) begin
            pe_n++;
            pe_cyc = cyc;
        end
        if (bus.stp_err === 1'b1) begin
            se_n++;
            se_cyc = cyc;
        end
    end
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic clear_mon();
        dv_n = 0; pe_n = 0; se_n = 0;
        dv_cyc = -1; dv_cyc_prev = -1; pe_cyc = -1; se_cyc = -1;
    endtask
    // one frame; config is scrambled after the start cycle to show it is latched at detect
    task automatic send_frame(input logic [7:0] d, input int p, input int bl, input logic pe,
                              input logic pt, input logic pb, input logic sb, output int t0);
        bus.Prescale = 6'(p); bus.PAR_EN = pe; bus.PAR_TYP = pt; bus.RX_IN = 1'b0;
        t0 = cyc;
        tick(1);
        bus.Prescale = 6'(p + 9); bus.PAR_EN = ~pe; bus.PAR_TYP = ~pt;
        tick(bl - 1);
        for (int i = 0; i < 8; i++) begin
            bus.RX_IN = d[i];
            tick(bl);
        end
        if (pe) begin
            bus.RX_IN = pb;
            tick(bl);
        end
        bus.RX_IN = sb;
        tick(bl);
    endtask
    task automatic test_reset();
        rst = 1'b1; bus.RX_IN = 1'b1; bus.Prescale = 6'd8; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0;
        tick(3);
        checks++; if (bus.P_DATA !== 8'h00) begin errors++; $display("FAIL reset_p_data: got %0h expected 0", bus.P_DATA); end
        checks++; if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b expected 0", bus.data_valid); end
        checks++; if (bus.par_err !== 1'b0) begin errors++; $display("FAIL reset_par_err: got %b expected 0", bus.par_err); end
        checks++; if (bus.stp_err !== 1'b0) begin errors++; $display("FAIL reset_stp_err: got %b expected 0", bus.stp_err); end
        rst = 1'b0;
        tick(2);
    endtask
    task automatic test_basic();
        int t0;
        clear_mon();
        send_frame(8'hA5, 8, 8, 1'b0, 1'b0, 1'b0, 1'b1, t0);
        tick(4);
        checks++; if (dv_n !== 1) begin errors++; $display("FAIL basic_dv_count: got %0d expected 1", dv_n); end
        checks++; if (dv_cyc !== t0 + 81) begin errors++; $display("FAIL basic_dv_cycle: got %0d expected %0d", dv_cyc, t0 + 81); end
        checks++; if (dv_data !== 8'hA5) begin errors++; $display("FAIL basic_data: got %0h expected a5", dv_data); end
        checks++; if (pe_n + se_n !== 0) begin errors++; $display("FAIL basic_err_pulses: got %0d expected 0", pe_n + se_n); end
    endtask
    task automatic test_small_prescale();
        int t0;
        clear_mon();
        send_frame(8'h96, 2, 4, 1'b0, 1'b0, 1'b0, 1'b1, t0);
        tick(4);
        checks++; if (dv_n !== 1) begin errors++; $display("FAIL presc_min_dv_count: got %0d expected 1", dv_n); end
        checks++; if (dv_cyc !== t0 + 41) begin errors++; $display("FAIL presc_min_cycle: got %0d expected %0d", dv_cyc, t0 + 41); end
        checks++; if (dv_data !== 8'h96) begin errors++; $display("FAIL presc_min_data: got %0h expected 96", dv_data); end
    endtask
    task automatic test_parity();
        int t0;
        clear_mon();
        send_frame(8'h3C, 16, 16, 1'b1, 1'b0, 1'b0, 1'b1, t0);
        tick(4);
        checks++; if (dv_n !== 1 || pe_n !== 0) begin errors++; $display("FAIL par_even_ok_counts: got dv=%0d pe=%0d expected dv=1 pe=0", dv_n, pe_n); end
        checks++; if (dv_cyc !== t0 + 177) begin errors++; $display("FAIL par_even_ok_cycle: got %0d expected %0d", dv_cyc, t0 + 177); end
        checks++; if (dv_data !== 8'h3C) begin errors++; $display("FAIL par_even_ok_data: got %0h expected 3c", dv_data); end
        clear_mon();
        send_frame(8'h3C, 16, 16, 1'b1, 1'b0, 1'b1, 1'b1, t0);
        tick(4);
        checks++; if (pe_n !== 1) begin errors++; $display("FAIL par_bad_pe_count: got %0d expected 1", pe_n); end
        checks++; if (pe_cyc !== t0 + 177) begin errors++; $display("FAIL par_bad_pe_cycle: got %0d expected %0d", pe_cyc, t0 + 177); end
        checks++; if (dv_n !== 0 || se_n !== 0) begin errors++; $display("FAIL par_bad_other: got dv=%0d se=%0d expected 0 0", dv_n, se_n); end
        checks++; if (bus.P_DATA !== 8'h3C) begin errors++; $display("FAIL par_bad_hold: got %0h expected 3c", bus.P_DATA); end
        clear_mon();
        send_frame(8'hC3, 16, 16, 1'b1, 1'b1, 1'b1, 1'b1, t0);
        tick(4);
        checks++; if (dv_n !== 1 || pe_n !== 0) begin errors++; $display("FAIL par_odd_counts: got dv=%0d pe=%0d expected dv=1 pe=0", dv_n, pe_n); end
        checks++; if (bus.P_DATA !== 8'hC3) begin errors++; $display("FAIL par_odd_data: got %0h expected c3", bus.P_DATA); end
    endtask
    task automatic test_stop_break();
        int t0;
        clear_mon();
        send_frame(8'h00, 8, 8, 1'b0, 1'b0, 1'b0, 1'b0, t0);
        tick(90);
        checks++; if (se_n !== 1) begin errors++; $display("FAIL stop_se_count: got %0d expected 1", se_n); end
        checks++; if (se_cyc !== t0 + 81) begin errors++; $display("FAIL stop_se_cycle: got %0d expected %0d", se_cyc, t0 + 81); end
        checks++; if (dv_n !== 0 || pe_n !== 0) begin errors++; $display("FAIL stop_other: got dv=%0d pe=%0d expected 0 0", dv_n, pe_n); end
        checks++; if (bus.P_DATA !== 8'hC3) begin errors++; $display("FAIL stop_hold: got %0h expected c3", bus.P_DATA); end
        bus.RX_IN = 1'b1;
        tick(2);
        clear_mon();
        send_frame(8'h55, 8, 8, 1'b0, 1'b0, 1'b0, 1'b1, t0);
        tick(4);
        checks++; if (dv_n !== 1 || se_n !== 0) begin errors++; $display("FAIL break_exit_counts: got dv=%0d se=%0d expected 1 0", dv_n, se_n); end
        checks++; if (dv_cyc !== t0 + 81) begin errors++; $display("FAIL break_exit_cycle: got %0d expected %0d", dv_cyc, t0 + 81); end
        checks++; if (dv_data !== 8'h55) begin errors++; $display("FAIL break_exit_data: got %0h expected 55", dv_data); end
    endtask
    task automatic test_glitch();
        int t0;
        clear_mon();
        bus.Prescale = 6'd16; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0;
        bus.RX_IN = 1'b0;
        tick(3);
        bus.RX_IN = 1'b1;
        tick(9);
        send_frame(8'h5A, 16, 16, 1'b0, 1'b0, 1'b0, 1'b1, t0);
        tick(4);
        checks++; if (dv_n !== 1 || pe_n + se_n !== 0) begin errors++; $display("FAIL glitch_counts: got dv=%0d err=%0d expected 1 0", dv_n, pe_n + se_n); end
        checks++; if (dv_cyc !== t0 + 161) begin errors++; $display("FAIL glitch_cycle: got %0d expected %0d", dv_cyc, t0 + 161); end
        checks++; if (dv_data !== 8'h5A) begin errors++; $display("FAIL glitch_data: got %0h expected 5a", dv_data); end
    endtask
    task automatic test_back_to_back();
        int t0a, t0b;
        clear_mon();
        send_frame(8'h12, 32, 32, 1'b0, 1'b0, 1'b0, 1'b1, t0a);
        send_frame(8'hEF, 32, 32, 1'b0, 1'b0, 1'b0, 1'b1, t0b);
        tick(5);
        checks++; if (dv_n !== 2) begin errors++; $display("FAIL b2b_dv_count: got %0d expected 2", dv_n); end
        checks++; if (dv_cyc_prev !== t0a + 321) begin errors++; $display("FAIL b2b_first_cycle: got %0d expected %0d", dv_cyc_prev, t0a + 321); end
        checks++; if (dv_cyc - dv_cyc_prev !== 320) begin errors++; $display("FAIL b2b_spacing: got %0d expected 320", dv_cyc - dv_cyc_prev); end
        checks++; if (dv_data_prev !== 8'h12) begin errors++; $display("FAIL b2b_first_data: got %0h expected 12", dv_data_prev); end
        checks++; if (dv_data !== 8'hEF) begin errors++; $display("FAIL b2b_second_data: got %0h expected ef", dv_data); end
    endtask
    task automatic test_reset_midframe();
        int t0;
        clear_mon();
        bus.Prescale = 6'd8; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0;
        bus.RX_IN = 1'b0;
        tick(8);
        for (int i = 0; i < 4; i++) begin
            bus.RX_IN = i[0];
            tick(8);
        end
        rst = 1'b1; bus.RX_IN = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(100);
        checks++; if (dv_n + pe_n + se_n !== 0) begin errors++; $display("FAIL abort_pulses: got %0d expected 0", dv_n + pe_n + se_n); end
        checks++; if (bus.P_DATA !== 8'h00) begin errors++; $display("FAIL abort_p_data: got %0h expected 0", bus.P_DATA); end
        send_frame(8'h81, 8, 8, 1'b0, 1'b0, 1'b0, 1'b1, t0);
        tick(4);
        checks++; if (dv_n !== 1 || dv_cyc !== t0 + 81) begin errors++; $display("FAIL after_abort_dv: got n=%0d cyc=%0d expected 1 %0d", dv_n, dv_cyc, t0 + 81); end
        checks++; if (dv_data !== 8'h81) begin errors++; $display("FAIL after_abort_data: got %0h expected 81", dv_data); end
    endtask
`ifdef UART_RX_MAJORITY_EN
    task automatic test_majority();
        clear_mon();
        bus.Prescale = 6'd16; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0;
        bus.RX_IN = 1'b0;
        tick(16 + 48 + 9);
        bus.RX_IN = 1'b1;
        tick(1);
        bus.RX_IN = 1'b0;
        tick(6 + 64);
        bus.RX_IN = 1'b1;
        tick(20);
        checks++; if (dv_n !== 1) begin errors++; $display("FAIL majority_dv_count: got %0d expected 1", dv_n); end
        checks++; if (dv_data !== 8'h00) begin errors++; $display("FAIL majority_data: got %0h expected 0", dv_data); end
    endtask
`endif
    initial begin
        clear_mon();
        test_reset();
        test_basic();
        test_small_prescale();
        test_parity();
        test_stop_break();
        test_glitch();
        test_back_to_back();
        test_reset_midframe();
`ifdef UART_RX_MAJORITY_EN
        test_majority();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
